// File: rtl/pcie_dma_arbiter.sv
// Round-robin arbiter sharing one PCIe DMA memory port among NREQ requesters, one transaction in flight.
// Accept->o_mem_valid 1 cycle, response->o_resp_valid 1 cycle; requesters see ready only in IDLE, mem port held until i_mem_ready.
module pcie_dma_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]    i_req_valid,
  input  logic [NREQ-1:0]    i_req_write,
  input  logic [NREQ*8-1:0]  i_req_wstrb,
  input  logic [NREQ*13-1:0] i_req_addr,
  input  logic [NREQ*64-1:0] i_req_wdata,
  output logic [NREQ-1:0]    o_req_ready,
  output logic [NREQ-1:0]    o_resp_valid,
  output logic [63:0]        o_resp_rdata,
  output logic               o_resp_err,
  output logic               o_mem_valid,
  output logic               o_mem_write,
  output logic [7:0]         o_mem_wstrb,
  output logic [12:0]        o_mem_addr,
  output logic [63:0]        o_mem_wdata,
  input  logic               i_mem_ready,
  input  logic               i_mem_resp_valid,
  input  logic [63:0]        i_mem_resp_rdata,
  input  logic               i_mem_resp_err,
  output logic [3:0]         o_state,
  output logic [15:0]        o_req_cnt,
  output logic [7:0]         o_err_cnt
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic        write;
    logic [7:0]  wstrb;
    logic [12:0] addr;
    logic [63:0] wdata;
  } payload_t;

  state_t           state_q, state_nxt;
  payload_t         payload_q, payload_sel;
  logic [IDXW-1:0]  last_q, gnt_q, gnt_idx;
  logic             gnt_found;
  logic [15:0]      timer_q, timer_inc;
  logic             timeout_hit;
  logic [63:0]      rdata_q;
  logic             rerr_q;
  logic [15:0]      req_cnt_q;
  logic [7:0]       err_cnt_q;
  logic             err_bump;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!gnt_found && i_req_valid[(int'(last_q) + i) % NREQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDXW'((int'(last_q) + i) % NREQ);
      end
    end
  end

  always_comb begin
    payload_sel.write = i_req_write[gnt_idx];
    payload_sel.wstrb = i_req_wstrb[int'(gnt_idx)*8 +: 8];
    payload_sel.addr  = i_req_addr[int'(gnt_idx)*13 +: 13];
    payload_sel.wdata = i_req_wdata[int'(gnt_idx)*64 +: 64];
  end

  // Timeout fires on the WAIT cycle whose increment brings the timer to TIMEOUT.
  assign timer_inc   = timer_q + 16'd1;
  assign timeout_hit = (timer_inc == TIMEOUT_VAL);

  always_comb begin
    err_bump = 1'b0;
    case (state_q)
      ST_IDLE, ST_REQ: err_bump = i_mem_resp_valid;
      ST_WAIT:         err_bump = i_mem_resp_valid ? i_mem_resp_err : timeout_hit;
      default:         err_bump = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (gnt_found) state_nxt = ST_REQ;
      ST_REQ:  if (i_mem_ready) state_nxt = ST_WAIT;
      ST_WAIT: if (i_mem_resp_valid || timeout_hit) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      payload_q <= '0;
      gnt_q     <= '0;
      last_q    <= IDXW'(NREQ - 1);
      timer_q   <= '0;
      rdata_q   <= '0;
      rerr_q    <= 1'b0;
      req_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_found) begin
            payload_q <= payload_sel;
            gnt_q     <= gnt_idx;
            last_q    <= gnt_idx;
            req_cnt_q <= req_cnt_q + 16'd1;
          end
        end
        ST_REQ: begin
          if (i_mem_ready) timer_q <= '0;
        end
        ST_WAIT: begin
          timer_q <= timer_inc;
          if (i_mem_resp_valid) begin
            rdata_q <= i_mem_resp_rdata;
            rerr_q  <= i_mem_resp_err;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            rerr_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_cnt_q <= '0;
    end else if (err_bump && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  always_comb begin
    o_req_ready  = '0;
    o_resp_valid = '0;
    o_resp_rdata = '0;
    o_resp_err   = 1'b0;
    o_mem_valid  = 1'b0;
    if (state_q == ST_IDLE && gnt_found) o_req_ready = NREQ'(1) << gnt_idx;
    if (state_q == ST_REQ) o_mem_valid = 1'b1;
    if (state_q == ST_RESP) begin
      o_resp_valid = NREQ'(1) << gnt_q;
      o_resp_rdata = rdata_q;
      o_resp_err   = rerr_q;
    end
    o_mem_write = payload_q.write;
    o_mem_wstrb = payload_q.wstrb;
    o_mem_addr  = payload_q.addr;
    o_mem_wdata = payload_q.wdata;
    o_state     = {2'b00, state_q};
    o_req_cnt   = req_cnt_q;
    o_err_cnt   = err_cnt_q;
  end

endmodule

// File: tb/tb_pcie_dma_arbiter.sv
// Directed bench for pcie_dma_arbiter: NREQ=4, TIMEOUT=16; inputs driven and outputs sampled on the falling edge.
module tb_pcie_dma_arbiter;

  localparam int NREQ = 4;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [NREQ-1:0]    i_req_valid;
  logic [NREQ-1:0]    i_req_write;
  logic [NREQ*8-1:0]  i_req_wstrb;
  logic [NREQ*13-1:0] i_req_addr;
  logic [NREQ*64-1:0] i_req_wdata;
  logic [NREQ-1:0]    o_req_ready;
  logic [NREQ-1:0]    o_resp_valid;
  logic [63:0]        o_resp_rdata;
  logic               o_resp_err;
  logic               o_mem_valid;
  logic               o_mem_write;
  logic [7:0]         o_mem_wstrb;
  logic [12:0]        o_mem_addr;
  logic [63:0]        o_mem_wdata;
  logic               i_mem_ready;
  logic               i_mem_resp_valid;
  logic [63:0]        i_mem_resp_rdata;
  logic               i_mem_resp_err;
  logic [3:0]         o_state;
  logic [15:0]        o_req_cnt;
  logic [7:0]         o_err_cnt;

  int checks = 0;
  int errors = 0;

  pcie_dma_arbiter #(.NREQ(NREQ), .TIMEOUT(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .i_req_write(i_req_write), .i_req_wstrb(i_req_wstrb),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .o_req_ready(o_req_ready),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
    .o_mem_valid(o_mem_valid), .o_mem_write(o_mem_write), .o_mem_wstrb(o_mem_wstrb),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_ready(i_mem_ready),
    .i_mem_resp_valid(i_mem_resp_valid), .i_mem_resp_rdata(i_mem_resp_rdata),
    .i_mem_resp_err(i_mem_resp_err), .o_state(o_state), .o_req_cnt(o_req_cnt),
    .o_err_cnt(o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic clear_inputs();
    i_req_valid      = '0;
    i_req_write      = '0;
    i_req_wstrb      = '0;
    i_req_addr       = '0;
    i_req_wdata      = '0;
    i_mem_ready      = 1'b0;
    i_mem_resp_valid = 1'b0;
    i_mem_resp_rdata = '0;
    i_mem_resp_err   = 1'b0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
  endtask

  task automatic set_req(input int k, input logic wr, input logic [7:0] strb,
                         input logic [12:0] addr, input logic [63:0] data);
    i_req_write[k]          = wr;
    i_req_wstrb[k*8 +: 8]   = strb;
    i_req_addr[k*13 +: 13]  = addr;
    i_req_wdata[k*64 +: 64] = data;
  endtask

  // Drives one complete read from requester 0 with an immediate accept and response.
  task automatic run_txn(input logic err);
    i_req_valid = 4'b0001;
    step();
    i_req_valid = '0;
    i_mem_ready = 1'b1;
    step();
    i_mem_ready      = 1'b0;
    i_mem_resp_valid = 1'b1;
    i_mem_resp_err   = err;
    step();
    i_mem_resp_valid = 1'b0;
    i_mem_resp_err   = 1'b0;
    step();
  endtask

  task automatic test_reset();
    step();
    reset_dut();
    #1;
    checks++;
    if ({o_req_ready, o_resp_valid, o_resp_err, o_mem_valid, o_mem_write} !== 11'd0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0",
               {o_req_ready, o_resp_valid, o_resp_err, o_mem_valid, o_mem_write});
    end
    checks++;
    if ({o_resp_rdata, o_mem_wstrb, o_mem_addr, o_mem_wdata} !== 149'd0) begin
      errors++;
      $display("FAIL reset_data got nonzero data outputs");
    end
    checks++;
    if ({o_state, o_req_cnt, o_err_cnt} !== 28'd0) begin
      errors++;
      $display("FAIL reset_status got state %0d req %0d err %0d exp 0 0 0", o_state, o_req_cnt, o_err_cnt);
    end
  endtask

  task automatic test_single_read();
    reset_dut();
    set_req(2, 1'b0, 8'h00, 13'h0A5, 64'h0);
    i_req_valid = 4'b0100;
    #1;
    checks++;
    if (o_req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready got %b exp 0100", o_req_ready);
    end
    step();
    i_req_valid = '0;
    set_req(2, 1'b1, 8'hFF, 13'h1FFF, 64'hFFFF);
    i_mem_ready = 1'b1;
    #1;
    checks++;
    if ({o_mem_valid, o_mem_write, o_mem_addr, o_state} !== {1'b1, 1'b0, 13'h0A5, 4'd1}) begin
      errors++;
      $display("FAIL single_mem got valid %b write %b addr %h state %0d exp 1 0 0a5 1",
               o_mem_valid, o_mem_write, o_mem_addr, o_state);
    end
    step();
    i_mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    i_mem_resp_valid = 1'b1;
    i_mem_resp_rdata = 64'h1122334455667788;
    #1;
    checks++;
    if ({o_state, o_resp_valid} !== {4'd2, 4'b0000}) begin
      errors++; $display("FAIL single_wait got state %0d resp %b exp 2 0000", o_state, o_resp_valid);
    end
    step();
    i_mem_resp_valid = 1'b0;
    i_mem_resp_rdata = '0;
    #1;
    checks++;
    if ({o_resp_valid, o_resp_rdata, o_resp_err} !== {4'b0100, 64'h1122334455667788, 1'b0}) begin
      errors++;
      $display("FAIL single_resp got valid %b rdata %h err %b exp 0100 1122334455667788 0",
               o_resp_valid, o_resp_rdata, o_resp_err);
    end
    checks++;
    if (o_req_cnt !== 16'd1) begin
      errors++; $display("FAIL single_reqcnt got %0d exp 1", o_req_cnt);
    end
    step();
    #1;
    checks++;
    if ({o_state, o_resp_valid} !== {4'd0, 4'b0000}) begin
      errors++; $display("FAIL single_idle got state %0d resp %b exp 0 0000", o_state, o_resp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_order [6];
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    reset_dut();
    for (int k = 0; k < NREQ; k++) set_req(k, 1'b0, 8'h00, 13'(k), 64'h0);
    i_req_valid = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      #1;
      checks++;
      if (o_req_ready !== exp_order[n]) begin
        errors++; $display("FAIL rr_grant%0d got %b exp %b", n, o_req_ready, exp_order[n]);
      end
      step();
      i_mem_ready = 1'b1;
      step();
      i_mem_ready      = 1'b0;
      i_mem_resp_valid = 1'b1;
      i_mem_resp_rdata = 64'hA000 + 64'(n);
      step();
      i_mem_resp_valid = 1'b0;
      #1;
      checks++;
      if ({o_resp_valid, o_resp_rdata} !== {exp_order[n], 64'hA000 + 64'(n)}) begin
        errors++;
        $display("FAIL rr_resp%0d got %b %h exp %b %h", n, o_resp_valid, o_resp_rdata,
                 exp_order[n], 64'hA000 + 64'(n));
      end
      step();
    end
    i_req_valid = '0;
    #1;
    checks++;
    if (o_req_cnt !== 16'd6) begin
      errors++; $display("FAIL rr_reqcnt got %0d exp 6", o_req_cnt);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    reset_dut();
    set_req(1, 1'b1, 8'hF0, 13'h1234, 64'hDEADBEEFCAFEF00D);
    i_req_valid = 4'b0010;
    step();
    i_req_valid = 4'b1000;
    set_req(1, 1'b0, 8'h0F, 13'h0001, 64'h0);
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if ({o_mem_valid, o_mem_write, o_mem_wstrb, o_mem_addr, o_mem_wdata, o_state, o_req_ready} !==
          {1'b1, 1'b1, 8'hF0, 13'h1234, 64'hDEADBEEFCAFEF00D, 4'd1, 4'b0000}) begin
        errors++;
        $display("FAIL bp_hold%0d got v %b w %b s %h a %h d %h st %0d rdy %b", c, o_mem_valid,
                 o_mem_write, o_mem_wstrb, o_mem_addr, o_mem_wdata, o_state, o_req_ready);
      end
      step();
    end
    i_req_valid = '0;
    i_mem_ready = 1'b1;
    step();
    i_mem_ready      = 1'b0;
    i_mem_resp_valid = 1'b1;
    step();
    i_mem_resp_valid = 1'b0;
    #1;
    checks++;
    if (o_resp_valid !== 4'b0010) begin
      errors++; $display("FAIL bp_resp got %b exp 0010", o_resp_valid);
    end
    step();
  endtask

  task automatic test_timeout();
    reset_dut();
    i_req_valid = 4'b0001;
    step();
    i_req_valid = '0;
    i_mem_ready = 1'b1;
    step();
    i_mem_ready = 1'b0;
    for (int c = 0; c < 16; c++) begin
      #1;
      checks++;
      if ({o_state, o_resp_valid} !== {4'd2, 4'b0000}) begin
        errors++; $display("FAIL to_wait%0d got state %0d resp %b exp 2 0000", c, o_state, o_resp_valid);
      end
      step();
    end
    #1;
    checks++;
    if ({o_resp_valid, o_resp_err, o_resp_rdata} !== {4'b0001, 1'b1, 64'h0}) begin
      errors++;
      $display("FAIL to_resp got valid %b err %b rdata %h exp 0001 1 0", o_resp_valid, o_resp_err, o_resp_rdata);
    end
    checks++;
    if (o_err_cnt !== 8'd1) begin
      errors++; $display("FAIL to_errcnt got %0d exp 1", o_err_cnt);
    end
    step();
    i_req_valid = 4'b0010;
    #1;
    checks++;
    if ({o_state, o_req_ready} !== {4'd0, 4'b0010}) begin
      errors++; $display("FAIL to_regrant got state %0d rdy %b exp 0 0010", o_state, o_req_ready);
    end
    step();
    i_req_valid = '0;
    #1;
    checks++;
    if ({o_state, o_req_cnt} !== {4'd1, 16'd2}) begin
      errors++; $display("FAIL to_accept got state %0d req %0d exp 1 2", o_state, o_req_cnt);
    end
  endtask

  task automatic test_resp_wins();
    reset_dut();
    i_req_valid = 4'b0100;
    step();
    i_req_valid = '0;
    i_mem_ready = 1'b1;
    step();
    i_mem_ready = 1'b0;
    for (int c = 0; c < 15; c++) step();
    i_mem_resp_valid = 1'b1;
    i_mem_resp_rdata = 64'h0123456789ABCDEF;
    step();
    i_mem_resp_valid = 1'b0;
    #1;
    checks++;
    if ({o_resp_valid, o_resp_err, o_resp_rdata, o_err_cnt} !==
        {4'b0100, 1'b0, 64'h0123456789ABCDEF, 8'd0}) begin
      errors++;
      $display("FAIL wins_resp got valid %b err %b rdata %h errcnt %0d exp 0100 0 0123456789abcdef 0",
               o_resp_valid, o_resp_err, o_resp_rdata, o_err_cnt);
    end
    step();
  endtask

  task automatic test_reset_wait();
    int seen;
    seen = 0;
    reset_dut();
    i_req_valid = 4'b0001;
    step();
    i_req_valid = '0;
    i_mem_ready = 1'b1;
    step();
    i_mem_ready = 1'b0;
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    #1;
    checks++;
    if ({o_state, o_req_cnt, o_err_cnt, o_resp_valid} !== 32'd0) begin
      errors++;
      $display("FAIL rst_clear got state %0d req %0d err %0d resp %b exp 0 0 0 0000",
               o_state, o_req_cnt, o_err_cnt, o_resp_valid);
    end
    i_mem_resp_valid = 1'b1;
    i_mem_resp_rdata = 64'h55;
    step();
    i_mem_resp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (o_resp_valid !== 4'b0000) seen++;
      step();
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL rst_noresp got %0d pulse cycles exp 0", seen);
    end
    #1;
    checks++;
    if ({o_state, o_req_cnt, o_err_cnt} !== {4'd0, 16'd0, 8'd1}) begin
      errors++;
      $display("FAIL rst_stray got state %0d req %0d err %0d exp 0 0 1", o_state, o_req_cnt, o_err_cnt);
    end
    i_req_valid = 4'b1111;
    #1;
    checks++;
    if (o_req_ready !== 4'b0001) begin
      errors++; $display("FAIL rst_grant got %b exp 0001", o_req_ready);
    end
    step();
    i_req_valid = '0;
    i_mem_ready = 1'b1;
    step();
    i_mem_ready      = 1'b0;
    i_mem_resp_valid = 1'b1;
    step();
    i_mem_resp_valid = 1'b0;
    step();
  endtask

  task automatic test_err_sat();
    reset_dut();
    for (int n = 0; n < 254; n++) run_txn(1'b1);
    #1;
    checks++;
    if (o_err_cnt !== 8'd254) begin
      errors++; $display("FAIL sat_254 got %0d exp 254", o_err_cnt);
    end
    for (int n = 0; n < 6; n++) run_txn(1'b1);
    #1;
    checks++;
    if ({o_err_cnt, o_req_cnt} !== {8'd255, 16'd260}) begin
      errors++; $display("FAIL sat_255 got err %0d req %0d exp 255 260", o_err_cnt, o_req_cnt);
    end
  endtask

  initial begin
    clear_inputs();
    i_rst = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_resp_wins();
    test_reset_wait();
    test_err_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
